// File: rtl/rf_operand_stage_pkg.sv
// Shared types and default sizes for the register-file operand stage.
// The FSM walks one instruction at a time through read, issue, result wait and write-back.
package rf_operand_stage_pkg;

    localparam int DEF_DW   = 16;
    localparam int DEF_NREG = 8;
    localparam int DEF_AW   = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READ     = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RES = 3'd3,
        WRITE    = 3'd4
    } state_t;

endpackage

// File: rtl/dec_onehot.sv
// Address to one-hot decoder with an enable.
// When the enable is low the whole output vector is zero.
module dec_onehot #(
    parameter int AW   = 3,
    parameter int NREG = 8
) (
    input  logic [AW-1:0]   addr,
    input  logic            en,
    output logic [NREG-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_operand_stage.sv
// Sequences one instruction through the register file: read both operands, hand them to the ALU,
// and optionally write the ALU result back through the per-register load enables.
module rf_operand_stage
    import rf_operand_stage_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [AW-1:0]   req_ra,
    input  logic [AW-1:0]   req_rb,
    input  logic [AW-1:0]   req_rw,
    input  logic            req_we,
    output logic [NREG-1:0] oeA,
    output logic [NREG-1:0] oeB,
    input  logic [DW-1:0]   DA,
    input  logic [DW-1:0]   DB,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [DW-1:0]   op_a,
    output logic [DW-1:0]   op_b,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic [DW-1:0]   res_data,
    output logic [NREG-1:0] ld,
    output logic [DW-1:0]   Din
);

    state_t          state;
    logic [AW-1:0]   ra_q;
    logic [AW-1:0]   rb_q;
    logic [AW-1:0]   rw_q;
    logic            we_q;
    logic            read_en;
    logic            write_en;

    // Enables come straight from the state register, so the async reset drops them without a clock edge.
    assign read_en  = (state == READ);
    assign write_en = (state == WRITE);

    dec_onehot #(.AW(AW), .NREG(NREG)) u_dec_a (
        .addr   (ra_q),
        .en     (read_en),
        .onehot (oeA)
    );

    dec_onehot #(.AW(AW), .NREG(NREG)) u_dec_b (
        .addr   (rb_q),
        .en     (read_en),
        .onehot (oeB)
    );

    dec_onehot #(.AW(AW), .NREG(NREG)) u_dec_ld (
        .addr   (rw_q),
        .en     (write_en),
        .onehot (ld)
    );

    // Handshake flags are registered alongside the state so they never follow a ready combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            op_valid  <= 1'b0;
            res_ready <= 1'b0;
            ra_q      <= '0;
            rb_q      <= '0;
            rw_q      <= '0;
            we_q      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            Din       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ra_q      <= req_ra;
                        rb_q      <= req_rb;
                        rw_q      <= req_rw;
                        we_q      <= req_we;
                        req_ready <= 1'b0;
                        state     <= READ;
                    end
                end
                READ: begin
                    op_a     <= DA;
                    op_b     <= DB;
                    op_valid <= 1'b1;
                    state    <= ISSUE;
                end
                ISSUE: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        if (we_q) begin
                            res_ready <= 1'b1;
                            state     <= WAIT_RES;
                        end else begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        Din       <= res_data;
                        res_ready <= 1'b0;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    op_valid  <= 1'b0;
                    res_ready <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_operand_stage.sv
// Directed bench: a behavioural 8x16 register file sits around the stage and
// every observed value is compared against hand-computed constants.
module tb_rf_operand_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_ra = '0;
    logic [2:0]  req_rb = '0;
    logic [2:0]  req_rw = '0;
    logic        req_we = 1'b0;
    logic [7:0]  oeA;
    logic [7:0]  oeB;
    logic [15:0] DA;
    logic [15:0] DB;
    logic        op_valid;
    logic        op_ready = 1'b0;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [15:0] res_data = '0;
    logic [7:0]  ld;
    logic [15:0] Din;

    int total = 0;
    int bad   = 0;
    int cycles;

    logic [15:0] rf [8] = '{16'h1111, 16'h2222, 16'h1234, 16'hBEEF,
                            16'h4444, 16'h00FF, 16'h6666, 16'h7777};

    rf_operand_stage dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ra    (req_ra),
        .req_rb    (req_rb),
        .req_rw    (req_rw),
        .req_we    (req_we),
        .oeA       (oeA),
        .oeB       (oeB),
        .DA        (DA),
        .DB        (DB),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .ld        (ld),
        .Din       (Din)
    );

    always #5 clk = ~clk;

    // Register file model: wired-OR of enabled tri-states, load on rising edge.
    always_comb begin
        DA = '0;
        DB = '0;
        for (int i = 0; i < 8; i++) begin
            if (oeA[i]) DA = DA | rf[i];
            if (oeB[i]) DB = DB | rf[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (ld[i]) rf[i] <= Din;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Bus monitor: never more than one enable per bus or load vector.
    always @(negedge clk) begin
        if (reset) begin
            checkOutput("oeA_atmost1", 32'($countones(oeA) <= 1), 32'd1);
            checkOutput("oeB_atmost1", 32'($countones(oeB) <= 1), 32'd1);
            checkOutput("ld_atmost1", 32'($countones(ld) <= 1), 32'd1);
        end
    end

    task automatic do_instr(input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rw,
                            input logic we, input logic [15:0] res,
                            input int op_stall, input int res_stall,
                            input logic [15:0] exp_a, input logic [15:0] exp_b,
                            input logic [7:0] exp_oea, input logic [7:0] exp_oeb,
                            input logic [7:0] exp_ld, output int n);
        n = 0;
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_ra = ra;
        req_rb = rb;
        req_rw = rw;
        req_we = we;
        @(negedge clk);
        req_valid = 1'b0;
        n++;
        checkOutput("oeA_read", 32'(oeA), 32'(exp_oea));
        checkOutput("oeB_read", 32'(oeB), 32'(exp_oeb));
        checkOutput("ld_read", 32'(ld), 32'd0);
        checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
        checkOutput("op_valid_read", 32'(op_valid), 32'd0);
        @(negedge clk);
        n++;
        checkOutput("op_valid_issue", 32'(op_valid), 32'd1);
        checkOutput("op_a", 32'(op_a), 32'(exp_a));
        checkOutput("op_b", 32'(op_b), 32'(exp_b));
        checkOutput("oeA_issue", 32'(oeA), 32'd0);
        checkOutput("oeB_issue", 32'(oeB), 32'd0);
        for (int i = 0; i < op_stall; i++) begin
            @(negedge clk);
            n++;
            checkOutput("op_valid_stall", 32'(op_valid), 32'd1);
            checkOutput("op_a_stall", 32'(op_a), 32'(exp_a));
            checkOutput("op_b_stall", 32'(op_b), 32'(exp_b));
            checkOutput("ld_op_stall", 32'(ld), 32'd0);
        end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        n++;
        checkOutput("op_valid_done", 32'(op_valid), 32'd0);
        if (we) begin
            checkOutput("res_ready_wait", 32'(res_ready), 32'd1);
            for (int i = 0; i < res_stall; i++) begin
                @(negedge clk);
                n++;
                checkOutput("res_ready_stall", 32'(res_ready), 32'd1);
                checkOutput("ld_res_stall", 32'(ld), 32'd0);
            end
            res_valid = 1'b1;
            res_data = res;
            @(negedge clk);
            res_valid = 1'b0;
            n++;
            checkOutput("ld_write", 32'(ld), 32'(exp_ld));
            checkOutput("Din_write", 32'(Din), 32'(res));
            checkOutput("res_ready_write", 32'(res_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        checkOutput("req_ready_back", 32'(req_ready), 32'd1);
        checkOutput("ld_idle", 32'(ld), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("oeA_in_reset", 32'(oeA), 32'd0);
        checkOutput("op_valid_in_reset", 32'(op_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("req_ready_rst", 32'(req_ready), 32'd1);
        checkOutput("res_ready_rst", 32'(res_ready), 32'd0);
        checkOutput("op_a_rst", 32'(op_a), 32'd0);
        checkOutput("Din_rst", 32'(Din), 32'd0);

        // Basic read / issue / write-back.
        do_instr(3'd2, 3'd5, 3'd7, 1'b1, 16'h1333, 0, 0, 16'h1234, 16'h00FF,
                 8'h04, 8'h20, 8'h80, cycles);
        checkOutput("basic_cycles", 32'(cycles), 32'd5);
        checkOutput("r7_written", 32'(rf[7]), 32'h1333);

        // Asynchronous reset in the middle of READ.
        req_valid = 1'b1; req_ra = 3'd2; req_rb = 3'd5; req_rw = 3'd7; req_we = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("oeA_pre_rst", 32'(oeA), 32'h04);
        #1 reset = 1'b0;
        #1;
        checkOutput("oeA_async", 32'(oeA), 32'd0);
        checkOutput("oeB_async", 32'(oeB), 32'd0);
        checkOutput("ld_async", 32'(ld), 32'd0);
        checkOutput("op_a_async", 32'(op_a), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("req_ready_rel", 32'(req_ready), 32'd1);
        checkOutput("op_a_rel", 32'(op_a), 32'd0);
        checkOutput("op_b_rel", 32'(op_b), 32'd0);

        // Same source register on both buses.
        do_instr(3'd3, 3'd3, 3'd4, 1'b1, 16'hABCD, 0, 0, 16'hBEEF, 16'hBEEF,
                 8'h08, 8'h08, 8'h10, cycles);
        checkOutput("r4_written", 32'(rf[4]), 32'hABCD);

        // Stalls on both handshakes add 4 + 3 cycles.
        do_instr(3'd0, 3'd1, 3'd6, 1'b1, 16'h5555, 4, 3, 16'h1111, 16'h2222,
                 8'h01, 8'h02, 8'h40, cycles);
        checkOutput("stall_cycles", 32'(cycles), 32'd12);
        checkOutput("r6_written", 32'(rf[6]), 32'h5555);

        // No write-back.
        do_instr(3'd4, 3'd6, 3'd2, 1'b0, 16'h0000, 0, 0, 16'hABCD, 16'h5555,
                 8'h10, 8'h40, 8'h00, cycles);
        checkOutput("nowb_cycles", 32'(cycles), 32'd3);
        checkOutput("r2_kept", 32'(rf[2]), 32'h1234);

        // Stray result outside WAIT_RES is ignored.
        res_valid = 1'b1; res_data = 16'hDEAD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("res_ready_stray", 32'(res_ready), 32'd0);
            checkOutput("ld_stray", 32'(ld), 32'd0);
        end
        res_valid = 1'b0;

        // Write r1 then read it back immediately.
        do_instr(3'd0, 3'd0, 3'd1, 1'b1, 16'h0042, 0, 0, 16'h1111, 16'h1111,
                 8'h01, 8'h01, 8'h02, cycles);
        do_instr(3'd1, 3'd2, 3'd0, 1'b0, 16'h0000, 0, 0, 16'h0042, 16'h1234,
                 8'h02, 8'h04, 8'h00, cycles);

        // Asynchronous reset during WRITE must not load the register.
        req_valid = 1'b1; req_ra = 3'd0; req_rb = 3'd0; req_rw = 3'd5; req_we = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        res_valid = 1'b1; res_data = 16'hDEAD;
        @(negedge clk);
        res_valid = 1'b0;
        checkOutput("ld_pre_rst", 32'(ld), 32'h20);
        #1 reset = 1'b0;
        #1;
        checkOutput("ld_async_write", 32'(ld), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("r5_no_partial", 32'(rf[5]), 32'h00FF);
        checkOutput("req_ready_rel2", 32'(req_ready), 32'd1);
        checkOutput("Din_rel2", 32'(Din), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_operand_stage.md
# rf_operand_stage

Sequencing stage that sits directly in front of and behind the 16-bit register file. Accepts one instruction request at a time and drives the per-register tri-state read enables onto the shared A/B buses. Captures the two operands and hands them to the ALU with a valid/ready handshake. Then writes the ALU result back through the per-register load enables, so it both feeds the register file and consumes what the file drives.

## Interface
- DW, 16, data width of registers, buses and ALU operands
- NREG, 8, number of registers in the file; one-hot enable width
- AW, 3, register address width, log2(NREG)

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserted (0) forces IDLE and clears all registered outputs immediately
- req_valid  in  1  instruction request present
- req_ready  out  1  stage accepts a request this cycle
- req_ra / req_rb  in  AW each  source register addresses for bus A / bus B
- req_rw  in  AW  destination register address
- req_we  in  1  request writes a result back
- oeA / oeB  out  NREG each  one-hot read enables to the register file's A/B tri-states
- DA / DB  in  DW each  shared read buses from the register file
- op_valid  out  1  op_a/op_b valid for the ALU
- op_ready  in  1  ALU takes operands
- op_a / op_b  out  DW each  captured operands
- res_valid  in  1  ALU result present
- res_ready  out  1  stage accepts result
- res_data  in  DW  ALU result
- ld  out  NREG  one-hot load enables to the register file
- Din  out  DW  write-back data to the register file

## Operation
- States: IDLE, READ, ISSUE, WAIT_RES, WRITE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch ra, rb, rw and we, then go to READ.
- READ (exactly 1 cycle):
  - oeA=onehot(ra) and oeB=onehot(rb).
  - On the closing edge, op_a<=DA and op_b<=DB; go to ISSUE.
  - ra==rb is legal: both buses carry the same register.
- ISSUE:
  - op_valid=1, with op_a/op_b held stable.
  - On op_ready: go to WAIT_RES if we=1, otherwise go to IDLE.
- WAIT_RES:
  - res_ready=1.
  - On res_valid, Din<=res_data; go to WRITE.
- WRITE (exactly 1 cycle):
  - ld=onehot(rw), with Din stable for the whole cycle; go to IDLE.
- Contention rule: oeA and oeB are all-zero in every state except READ. In READ each has exactly one bit set.
- ld is all-zero outside WRITE and has exactly one bit set in WRITE.
- req_ready, op_valid and res_ready are asserted only in their own state; valid signals never depend combinationally on the matching ready.
- Reset values: state=IDLE; oeA, oeB, ld, op_a, op_b, Din, op_valid and res_ready all 0.
- req_ready is 1 after reset deasserts.

## Timing
- Accept-to-op_valid latency: request accepted at edge N, READ during cycle N+1, op_valid high from cycle N+2.
- Result-to-write: res_valid sampled at edge M, ld high in cycle M+1, register updated at edge M+2.
- Minimum throughput, we=1 and zero-wait ALU: 5 cycles per instruction. With we=0: 3 cycles.
- No new request is accepted until return to IDLE; req_ready drops the cycle after acceptance.
- op_ready held low stalls ISSUE indefinitely; operands do not change.
- res_valid held low stalls WAIT_RES indefinitely.
- A result arriving while not in WAIT_RES is ignored (res_ready=0).
- Reset asserted mid-operation, including in READ or WRITE: enables drop asynchronously. No partial write occurs and no bus stays driven. The stage resumes in IDLE.
- Write-after-read to the same register: the next request's READ occurs after WRITE's edge, so it sees the new value; no bypass is needed.

## Structure
- Shared package holds:
  - state enum (IDLE, READ, ISSUE, WAIT_RES, WRITE)
  - DW, NREG, AW defaults
- Sub-module dec_onehot (AW in, NREG out, with enable input), instantiated three times for oeA, oeB and ld.
- The enable input is tied to the state decode, so all outputs are zero when disabled.
- Remainder is a single FSM plus operand, address and result registers.

## Test plan
- Reset: reset=0 mid-READ with oeA=8'h04. Required: oeA, oeB and ld go to 0 without waiting for a clock edge. After release, req_ready=1 and op_a=op_b=0.
- Basic: regs r2=16'h1234, r5=16'h00FF; request ra=2, rb=5, rw=7, we=1; ALU returns 16'h1333. Required:
  - oeA=8'h04 and oeB=8'h20 for one cycle.
  - op_a=16'h1234 and op_b=16'h00FF.
  - ld=8'h80 for one cycle with Din=16'h1333.
- Same source: ra=rb=3 with r3=16'hBEEF. Required: op_a=op_b=16'hBEEF, and oeA=oeB=8'h08 only in READ.
- Stalls: hold op_ready=0 for 4 cycles, then hold res_valid=0 for 3 cycles. Required: operands stable, no ld pulse until the result arrives, total latency extended by exactly 7 cycles.
- No write-back: we=0. Required: ld stays 8'h00 throughout, and req_ready returns 1 the cycle after the op handshake.
- Back-to-back hazard: write r1=16'h0042, then immediately request ra=1. Required: op_a=16'h0042, and the bus monitor sees at most one oe bit per bus in every cycle.
